dmem_access_arbiter: RTL and testbench
======================================

// Module: dmem_access_arbiter
// PURPOSE
//  Shares the single-port data memory (async read, sync write, 16-bit words) between the CPU
//  load/store path and an external requester (debug/loader/DMA). CPU has fixed priority; an
//  aging counter bounds external wait. After reset, a clear sequencer zeroes all words before
//  either requester is served. Sits between the CPU datapath / ext bus and the data memory.
// PARAMETERS
//  DEPTH          512  words in data memory; valid addresses 0..DEPTH-1
//  MAX_WAIT       4    max cycles ext_req may wait while the CPU holds the port
//  CLEAR_ON_RESET 1    1: zero the memory after reset; 0: go straight to RUN
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  cpu_req     in   1   CPU load/store this cycle
//  cpu_we      in   1   1 = store, 0 = load
//  cpu_addr    in   16  CPU word address (ALU result)
//  cpu_wdata   in   16  store data
//  cpu_rdata   out  16  load data, combinational, same cycle
//  cpu_stall   out  1   CPU must hold its request and freeze the PC
//  ext_req     in   1   external access request; held with fields stable until ext_gnt
//  ext_we      in   1   1 = write, 0 = read
//  ext_addr    in   16  external word address
//  ext_wdata   in   16  external write data
//  ext_gnt     out  1   access performed this cycle (combinational)
//  ext_rdata   out  16  registered read data
//  ext_rvalid  out  1   one-cycle pulse, cycle after a granted ext read
//  addr_err    out  1   registered pulse: granted access had addr >= DEPTH
//  init_done   out  1   high once clear finished (or immediately if CLEAR_ON_RESET=0)
//  mem_we/mem_addr[15:0]/mem_wdata[15:0] out, mem_rdata[15:0] in: data memory port
// BEHAVIOUR
//  Reset (async, rst_n=0): state=CLEAR (RUN if CLEAR_ON_RESET=0), clr_cnt=0, wait_cnt=0,
//   ext_rdata=0, ext_rvalid=0, addr_err=0, init_done=0 (1 if no clear). Reset mid-access
//   abandons it; a clear in progress restarts from address 0.
//  CLEAR: mem_we=1, mem_addr=clr_cnt, mem_wdata=0; clr_cnt+1 per cycle; cpu_stall=1 (even if
//   !cpu_req), ext_gnt=0, wait_cnt held at 0. On clr_cnt==DEPTH-1 write -> RUN, init_done=1
//   next cycle. Clear takes exactly DEPTH cycles.
//  RUN arbitration (combinational, per cycle):
//   ext_win = ext_req & (!cpu_req | wait_cnt==MAX_WAIT).
//   ext_win: port driven from ext_*, ext_gnt=1, cpu_stall=cpu_req. Else if cpu_req: port from
//   cpu_*, cpu_stall=0. Idle: mem_we=0, mem_addr=0, mem_wdata=0.
//  wait_cnt: 0 on ext_gnt or !ext_req; +1 when ext_req & !ext_gnt; saturates at MAX_WAIT.
//   Ext worst-case latency MAX_WAIT+1 cycles from request to grant.
//  Range check: addr >= DEPTH -> mem_we forced 0, read data returned as 0 to the winner,
//   addr_err pulses next cycle. mem_addr is still driven with the raw address.
//  Reads: cpu_rdata = mem_rdata when CPU is the winner, 0 otherwise. ext_rdata captures
//   mem_rdata at the granted ext read edge; ext_rvalid=1 the following cycle only.
//   Ext writes produce no rvalid.
//  Back-to-back ext grants allowed when CPU idle; stalled CPU is served the cycle after.
//  No simultaneous writes: exactly one source drives mem_* per cycle.
// STRUCTURE
//  defines.vh: DMEM_DEPTH, DMEM_AW (9), arbiter state encoding (ARB_CLEAR, ARB_RUN).
//  One sub-module: dmem_clear_seq (clr_cnt, done flag); arbitration and ext read regs inline.
// TESTING
//  Reset, CLEAR_ON_RESET=1, DEPTH=512: 512 cycles mem_we=1 with data 0 and addr 0..511,
//   cpu_stall=1 throughout; init_done rises at cycle 513; all words read back 0.
//  RUN, cpu_req store 0x1234 @0x0010 then load @0x0010 -> cpu_stall=0, cpu_rdata=0x1234
//   same cycle.
//  cpu_req held 1, ext read @0x0020 (holding 0xBEEF), MAX_WAIT=4 -> ext_gnt on 5th cycle,
//   cpu_stall=1 that cycle only, ext_rvalid=1 with ext_rdata=0xBEEF the next cycle.
//  CPU idle, ext write 0x00AA @0x0005 -> ext_gnt same cycle, no rvalid, CPU load reads 0x00AA.
//  ext write @0x0200 (=DEPTH) -> mem_we=0, addr_err=1 next cycle, memory unchanged.
//  rst_n pulsed low at clear count 100 -> clear restarts at 0; outputs return to reset values.

Source files
------------

// File: rtl/dmem_access_arbiter_pkg.sv
// Shared constants, state/winner encodings and the address range helper
// for the data-memory access arbiter.
package dmem_access_arbiter_pkg;

  localparam int DMEM_DEPTH          = 512;
  localparam int DMEM_AW             = 9;
  localparam int DMEM_DW             = 16;
  localparam int DMEM_MAX_WAIT       = 4;
  localparam bit DMEM_CLEAR_ON_RESET = 1'b1;

  typedef enum logic {
    ARB_CLEAR = 1'b0,
    ARB_RUN   = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_CPU  = 2'd1,
    WIN_EXT  = 2'd2
  } arb_win_t;

  // The raw 16-bit bus address can exceed the memory; this decides whether it lands inside.
  function automatic logic addr_in_range(input logic [15:0] addr, input int depth);
    return (32'(addr) < 32'(depth));
  endfunction

endpackage

// File: rtl/dmem_access_arbiter_if.sv
// Bundles the CPU load/store path, the external requester and the data
// memory port as seen by the arbiter (slave) and its environment (master).
import dmem_access_arbiter_pkg::*;

interface dmem_access_arbiter_if;

  logic               cpu_req;
  logic               cpu_we;
  logic [DMEM_DW-1:0] cpu_addr;
  logic [DMEM_DW-1:0] cpu_wdata;
  logic [DMEM_DW-1:0] cpu_rdata;
  logic               cpu_stall;

  logic               ext_req;
  logic               ext_we;
  logic [DMEM_DW-1:0] ext_addr;
  logic [DMEM_DW-1:0] ext_wdata;
  logic               ext_gnt;
  logic [DMEM_DW-1:0] ext_rdata;
  logic               ext_rvalid;

  logic               addr_err;
  logic               init_done;

  logic               mem_we;
  logic [DMEM_DW-1:0] mem_addr;
  logic [DMEM_DW-1:0] mem_wdata;
  logic [DMEM_DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rdata, ext_rvalid,
    output addr_err, init_done,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  addr_err, init_done,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_access_arbiter_clear_seq.sv
// Post-reset clear sequencer: walks the write address from 0 to DEPTH-1,
// one word per cycle while enabled, then raises a sticky done flag.
import dmem_access_arbiter_pkg::*;

module dmem_access_arbiter_clear_seq #(
  parameter int DEPTH          = DMEM_DEPTH,
  parameter bit CLEAR_ON_RESET = DMEM_CLEAR_ON_RESET
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic [15:0] o_clr_addr,
  output logic        o_last,
  output logic        o_done
);

  localparam logic [15:0] LP_LAST = 16'(DEPTH - 1);

  logic [15:0] r_clr_cnt;
  logic        r_done;

  assign o_clr_addr = r_clr_cnt;
  assign o_last     = i_en & (r_clr_cnt == LP_LAST);
  assign o_done     = r_done;

  // Without a clear the memory is usable straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_cnt <= 16'd0;
      r_done    <= CLEAR_ON_RESET ? 1'b0 : 1'b1;
    end else if (i_en) begin
      if (o_last) begin
        r_clr_cnt <= 16'd0;
        r_done    <= 1'b1;
      end else begin
        r_clr_cnt <= r_clr_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Single-port data memory arbiter: CPU has fixed priority, an aging counter
// bounds the external requester's wait, and memory is zeroed after reset.
import dmem_access_arbiter_pkg::*;

// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_CLEAR | zeroing memory word by word, both requesters held off
// ARB_RUN   | per-cycle arbitration between CPU and external requester
module dmem_access_arbiter #(
  parameter int DEPTH          = DMEM_DEPTH,
  parameter int MAX_WAIT       = DMEM_MAX_WAIT,
  parameter bit CLEAR_ON_RESET = DMEM_CLEAR_ON_RESET
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_access_arbiter_if.slave bus
);

  localparam int             WW          = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0]  LP_MAX_WAIT = WW'(MAX_WAIT);

  arb_state_t    r_state;
  logic [WW-1:0] r_wait_cnt;
  logic [15:0]   r_ext_rdata;
  logic          r_ext_rvalid;
  logic          r_addr_err;

  logic [15:0]   w_clr_addr;
  logic          w_clr_last;
  logic          w_clr_done;
  arb_win_t      w_win;
  logic [15:0]   w_addr;
  logic          w_in_range;
  logic [15:0]   w_rdata_safe;

  dmem_access_arbiter_clear_seq #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (r_state == ARB_CLEAR),
    .o_clr_addr (w_clr_addr),
    .o_last     (w_clr_last),
    .o_done     (w_clr_done)
  );

  // Once the external side has aged to MAX_WAIT it takes the port even over a busy CPU.
  always_comb begin
    w_win = WIN_NONE;
    if (r_state == ARB_RUN) begin
      if (bus.ext_req && (!bus.cpu_req || (r_wait_cnt == LP_MAX_WAIT)))
        w_win = WIN_EXT;
      else if (bus.cpu_req)
        w_win = WIN_CPU;
    end
  end

  assign w_addr       = (w_win == WIN_EXT) ? bus.ext_addr : bus.cpu_addr;
  assign w_in_range   = addr_in_range(w_addr, DEPTH);
  assign w_rdata_safe = w_in_range ? bus.mem_rdata : 16'd0;

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 16'd0;
    bus.mem_wdata = 16'd0;
    bus.cpu_rdata = 16'd0;
    bus.cpu_stall = 1'b0;
    bus.ext_gnt   = 1'b0;
    case (r_state)
      ARB_CLEAR: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = w_clr_addr;
        bus.cpu_stall = 1'b1;
      end
      ARB_RUN: begin
        case (w_win)
          WIN_EXT: begin
            bus.mem_we    = bus.ext_we & w_in_range;
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
            bus.ext_gnt   = 1'b1;
            bus.cpu_stall = bus.cpu_req;
          end
          WIN_CPU: begin
            bus.mem_we    = bus.cpu_we & w_in_range;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.cpu_rdata = w_rdata_safe;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= CLEAR_ON_RESET ? ARB_CLEAR : ARB_RUN;
      r_wait_cnt   <= '0;
      r_ext_rdata  <= 16'd0;
      r_ext_rvalid <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_ext_rvalid <= 1'b0;
      r_addr_err   <= 1'b0;
      case (r_state)
        ARB_CLEAR: begin
          r_wait_cnt <= '0;
          if (w_clr_last)
            r_state <= ARB_RUN;
        end
        ARB_RUN: begin
          if ((w_win == WIN_EXT) || !bus.ext_req)
            r_wait_cnt <= '0;
          else if (r_wait_cnt != LP_MAX_WAIT)
            r_wait_cnt <= r_wait_cnt + WW'(1);
          if ((w_win == WIN_EXT) && !bus.ext_we) begin
            r_ext_rdata  <= w_rdata_safe;
            r_ext_rvalid <= 1'b1;
          end
          if ((w_win != WIN_NONE) && !w_in_range)
            r_addr_err <= 1'b1;
        end
        default: r_state <= ARB_RUN;
      endcase
    end
  end

  assign bus.ext_rdata  = r_ext_rdata;
  assign bus.ext_rvalid = r_ext_rvalid;
  assign bus.addr_err   = r_addr_err;
  assign bus.init_done  = w_clr_done;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter with a behavioural data memory and
// a queue of expected external read data checked on each ext_rvalid.
module tb_dmem_access_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [15:0] q_ext[$];
  logic [15:0] mem [0:511];

  dmem_access_arbiter_if bus();

  dmem_access_arbiter #(
    .DEPTH          (512),
    .MAX_WAIT       (4),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Async read, sync write; addresses fold onto 9 bits so out-of-range leaks would show.
  assign bus.mem_rdata = mem[bus.mem_addr[8:0]];
  always @(posedge clk) if (bus.mem_we === 1'b1) mem[bus.mem_addr[8:0]] <= bus.mem_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic c_req, input logic c_we, input logic [15:0] c_addr,
                        input logic [15:0] c_wd, input logic e_req, input logic e_we,
                        input logic [15:0] e_addr, input logic [15:0] e_wd);
    bus.cpu_req   = c_req;
    bus.cpu_we    = c_we;
    bus.cpu_addr  = c_addr;
    bus.cpu_wdata = c_wd;
    bus.ext_req   = e_req;
    bus.ext_we    = e_we;
    bus.ext_addr  = e_addr;
    bus.ext_wdata = e_wd;
  endtask

  task automatic drive(input logic c_req, input logic c_we, input logic [15:0] c_addr,
                       input logic [15:0] c_wd, input logic e_req, input logic e_we,
                       input logic [15:0] e_addr, input logic [15:0] e_wd);
    @(negedge clk);
    set_in(c_req, c_we, c_addr, c_wd, e_req, e_we, e_addr, e_wd);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic check_rv(input logic exp);
    check("ext_rvalid", bus.ext_rvalid, exp);
    if (bus.ext_rvalid === 1'b1) begin
      if (q_ext.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL ext_rdata_queue observed=rvalid expected=no_pending_read");
      end else begin
        check("ext_rdata", bus.ext_rdata, q_ext.pop_front());
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_regs"}, {bus.ext_rdata, bus.ext_rvalid, bus.addr_err, bus.init_done},
          {16'h0, 1'b0, 1'b0, 1'b0});
    check({tag, "_ctl"}, {bus.cpu_stall, bus.ext_gnt, bus.cpu_rdata}, {1'b1, 1'b0, 16'h0});
    check({tag, "_port"}, {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 16'h0, 16'h0});
  endtask

  // Releases reset on the first cycle (no effect if already released) and checks n clear writes.
  task automatic run_clear(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      #1;
      check("clear_port", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 16'(i), 16'h0});
      check("clear_ctl", {bus.cpu_stall, bus.ext_gnt, bus.init_done, bus.ext_rvalid, bus.cpu_rdata},
            {1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 512; i++) mem[i] = 16'hDEAD;
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0);

    @(negedge clk); #1;
    check_reset_outputs("reset");

    run_clear(512);
    idle();
    check("init_done_rise", {bus.init_done, bus.cpu_stall, bus.ext_gnt}, {1'b1, 1'b0, 1'b0});
    check("run_idle_port", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b0, 16'h0, 16'h0});

    for (int a = 0; a < 512; a++) begin
      drive(1'b1, 1'b0, 16'(a), 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      check("readback_zero", {bus.cpu_stall, bus.cpu_rdata}, {1'b0, 16'h0});
    end

    // CPU store then load, same-cycle read data
    drive(1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0);
    check("cpu_store_port", {bus.cpu_stall, bus.mem_we, bus.mem_addr, bus.mem_wdata},
          {1'b0, 1'b1, 16'h0010, 16'h1234});
    drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("cpu_load", {bus.cpu_stall, bus.cpu_rdata}, {1'b0, 16'h1234});
    drive(1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0);

    // Aging: CPU busy every cycle, ext read wins on its 5th cycle
    q_ext.push_back(16'hBEEF);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0, 16'h0030, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0);
      check("aging_gnt", bus.ext_gnt, (k == 5));
      check("aging_stall", {bus.cpu_stall, bus.cpu_rdata}, {(k == 5), 16'h0});
      check_rv(1'b0);
    end
    drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_rv(1'b1);
    check("cpu_after_ext", {bus.cpu_stall, bus.cpu_rdata}, {1'b0, 16'h1234});
    idle();
    check_rv(1'b0);

    // Wait counter released by CPU going idle, then back-to-back ext reads
    q_ext.push_back(16'h1234);
    drive(1'b1, 1'b0, 16'h0030, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0);
    check("b2b_wait", {bus.ext_gnt, bus.cpu_stall}, {1'b0, 1'b0});
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0);
    check("b2b_gnt1", bus.ext_gnt, 1'b1);
    q_ext.push_back(16'hBEEF);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0);
    check("b2b_gnt2", bus.ext_gnt, 1'b1);
    check_rv(1'b1);
    idle();
    check_rv(1'b1);
    idle();
    check_rv(1'b0);

    // Ext write with CPU idle, then CPU reads it back
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0005, 16'h00AA);
    check("ext_wr_port", {bus.ext_gnt, bus.cpu_stall, bus.mem_we, bus.mem_addr, bus.mem_wdata},
          {1'b1, 1'b0, 1'b1, 16'h0005, 16'h00AA});
    drive(1'b1, 1'b0, 16'h0005, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_rv(1'b0);
    check("ext_wr_readback", bus.cpu_rdata, 16'h00AA);

    // Out-of-range ext write: suppressed, raw address still driven, error next cycle
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0200, 16'h5555);
    check("oor_wr_port", {bus.ext_gnt, bus.mem_we, bus.mem_addr, bus.addr_err},
          {1'b1, 1'b0, 16'h0200, 1'b0});
    drive(1'b1, 1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("oor_wr_err", {bus.addr_err, bus.ext_rvalid}, {1'b1, 1'b0});
    check("oor_wr_mem_kept", bus.cpu_rdata, 16'h0000);
    idle();
    check("oor_err_pulse", bus.addr_err, 1'b0);

    // Out-of-range ext read returns 0 even though the folded word holds data
    q_ext.push_back(16'h0000);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0210, 16'h0);
    check("oor_rd_gnt", bus.ext_gnt, 1'b1);
    idle();
    check_rv(1'b1);
    check("oor_rd_err", bus.addr_err, 1'b1);

    // Out-of-range CPU store and load
    drive(1'b1, 1'b1, 16'h0300, 16'h7777, 1'b0, 1'b0, 16'h0, 16'h0);
    check("cpu_oor_st", {bus.mem_we, bus.mem_addr, bus.cpu_stall}, {1'b0, 16'h0300, 1'b0});
    drive(1'b1, 1'b0, 16'h0100, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("cpu_oor_st_err", {bus.addr_err, bus.cpu_rdata}, {1'b1, 16'h0000});
    drive(1'b1, 1'b0, 16'h0210, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("cpu_oor_ld", {bus.cpu_rdata, bus.addr_err}, {16'h0000, 1'b0});
    idle();
    check("cpu_oor_ld_err", bus.addr_err, 1'b1);

    // Leave ext_rdata non-zero so the reset clear of it is visible
    q_ext.push_back(16'hBEEF);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0);
    idle();
    check_rv(1'b1);

    // Reset during RUN, then again at clear count 100
    set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_run");
    run_clear(100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_clr100");
    run_clear(512);
    idle();
    check("init_done_again", {bus.init_done, bus.cpu_stall}, {1'b1, 1'b0});
    drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("recleared_10", bus.cpu_rdata, 16'h0000);
    drive(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("recleared_20", bus.cpu_rdata, 16'h0000);
    drive(1'b1, 1'b0, 16'h0005, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("recleared_05", bus.cpu_rdata, 16'h0000);

    check("ext_queue_drained", 64'(q_ext.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
